// File: rtl/one_hot_demux_if.sv
// Stream bundle for one_hot_demux: one valid/ready input stream with a
// one-hot destination select, fanned out to CNT valid/ready output channels.
//
// Signals:
//   in_vld   beat valid (source -> demux)
//   in_rdy   beat accepted when in_vld & in_rdy (demux -> source)
//   in_data  WIDTH-bit payload
//   in_sel   CNT-bit one-hot destination select, qualified by in_vld
//   out_vld  per-channel valid, bit c is channel c (demux -> sinks)
//   out_rdy  per-channel ready (sinks -> demux)
//   out_data channel c occupies bits [(c+1)*WIDTH-1 : c*WIDTH]
//
// Modports:
//   master - the surrounding environment: drives the input beat and the
//            per-channel ready, observes in_rdy and the channel outputs.
//   slave  - the demux itself.
interface one_hot_demux_if #(
    parameter int WIDTH = 32,
    parameter int CNT   = 5
);
    logic                 in_vld;
    logic                 in_rdy;
    logic [WIDTH-1:0]     in_data;
    logic [CNT-1:0]       in_sel;
    logic [CNT-1:0]       out_vld;
    logic [CNT-1:0]       out_rdy;
    logic [WIDTH*CNT-1:0] out_data;

    modport master (
        output in_vld, in_data, in_sel, out_rdy,
        input  in_rdy, out_vld, out_data
    );

    modport slave (
        input  in_vld, in_data, in_sel, out_rdy,
        output in_rdy, out_vld, out_data
    );
endinterface

// File: rtl/one_hot_demux.sv
// one_hot_demux: routes one valid/ready stream to one of CNT output channels
// chosen by a one-hot select carried with each beat. Every channel has a
// one-entry register slice (1-cycle latency, independent backpressure).
// Illegal selects (zero or multi-hot) are consumed, dropped and logged.
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   bus      one_hot_demux_if.slave: in_vld/in_rdy/in_data/in_sel,
//            out_vld/out_rdy/out_data
//   err_clr  synchronous clear of err and err_cnt
//   err      sticky illegal-select flag
//   err_cnt  saturating count of dropped illegal beats
//
// Parameters:
//   WIDTH          data width of one channel
//   CNT            number of output channels
//   ONE_HOT_CHECK  1: detect, drop and count illegal selects
//                  0: no checking, lowest set bit wins, zero select dropped
module one_hot_demux #(
    parameter int WIDTH         = 32,
    parameter int CNT           = 5,
    parameter bit ONE_HOT_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    one_hot_demux_if.slave        bus,
    input  logic                  err_clr,
    output logic                  err,
    output logic [7:0]            err_cnt
);

    logic [CNT-1:0]       sel_lsb;
    logic [CNT-1:0]       tgt;
    logic                 legal;
    logic                 load;
    logic                 drop_err;

    logic [CNT-1:0]       vld_q, vld_d;
    logic [CNT*WIDTH-1:0] data_q, data_d;
    logic                 err_q, err_d;
    logic [7:0]           cnt_q, cnt_d;

    // Isolate the lowest set bit. A select is exactly one-hot iff it is
    // nonzero and equal to its own lowest set bit.
    always_comb begin
        sel_lsb = bus.in_sel & (~bus.in_sel + CNT'(1));
        tgt     = sel_lsb;
        if (ONE_HOT_CHECK) begin
            legal = (bus.in_sel != '0) && (sel_lsb == bus.in_sel);
        end else begin
            legal = (bus.in_sel != '0);
        end
    end

    // Illegal/dropped beats are always accepted so they never stall the
    // source. Ready is combinational from out_rdy of the target slot so a
    // slot can drain and reload on the same edge.
    assign bus.in_rdy = !rst && (!legal || (|(tgt & (~vld_q | bus.out_rdy))));

    assign load     = bus.in_vld && bus.in_rdy && legal;
    assign drop_err = ONE_HOT_CHECK && bus.in_vld && bus.in_rdy && !legal;

    always_comb begin
        // A full slot whose sink is ready empties unless reloaded below.
        vld_d  = vld_q & ~bus.out_rdy;
        data_d = data_q;
        for (int c = 0; c < CNT; c++) begin
            if (load && tgt[c]) begin
                vld_d[c]                  = 1'b1;
                data_d[c*WIDTH +: WIDTH]  = bus.in_data;
            end
        end

        // Clear first, then count, so a clear coinciding with an illegal
        // beat leaves err=1, err_cnt=1.
        err_d = err_q;
        cnt_d = cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
        if (drop_err) begin
            err_d = 1'b1;
            if (cnt_d != 8'hFF) begin
                cnt_d = cnt_d + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.out_vld  = vld_q;
    assign bus.out_data = data_q;
    assign err          = ONE_HOT_CHECK ? err_q : 1'b0;
    assign err_cnt      = ONE_HOT_CHECK ? cnt_q : 8'd0;

endmodule

// File: tb/tb_one_hot_demux.sv
module tb_one_hot_demux;

    localparam int W = 32;
    localparam int N = 5;

    logic       clk;
    logic       rst;
    logic       err_clr;
    logic       err;
    logic [7:0] err_cnt;
    logic       err0;
    logic [7:0] err_cnt0;

    one_hot_demux_if #(.WIDTH(W), .CNT(N)) a ();
    one_hot_demux_if #(.WIDTH(W), .CNT(N)) b ();

    one_hot_demux #(.WIDTH(W), .CNT(N), .ONE_HOT_CHECK(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (a),
        .err_clr (err_clr),
        .err     (err),
        .err_cnt (err_cnt)
    );

    one_hot_demux #(.WIDTH(W), .CNT(N), .ONE_HOT_CHECK(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .bus     (b),
        .err_clr (err_clr),
        .err     (err0),
        .err_cnt (err_cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          ch;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cur_ch = -1;
    bit    accepted;
    int    idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer a beat on the checked instance; ch is the hand-decoded target,
    // -1 when the beat must be dropped.
    task automatic offer(input logic [4:0] sel, input logic [31:0] d, input int ch);
        a.in_vld  = 1'b1;
        a.in_sel  = sel;
        a.in_data = d;
        cur_ch    = ch;
    endtask

    // Evaluate the handshake mid-cycle, record an accepted legal beat as
    // expected output, then advance past the next rising edge.
    task automatic tick();
        @(negedge clk);
        accepted = a.in_vld && a.in_rdy;
        if (accepted && cur_ch >= 0) begin
            sb.push_back('{ch: cur_ch, data: a.in_data});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every channel transfer must match the oldest expected beat
    // for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                if (a.out_vld[c] && a.out_rdy[c]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (idx < 0 && sb[i].ch == c) idx = i;
                    end
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_ch%0d: got %0h expected no beat", c, a.out_data[c*W +: W]);
                    end else begin
                        check($sformatf("data_ch%0d", c), 64'(a.out_data[c*W +: W]), 64'(sb[idx].data));
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        err_clr   = 1'b0;
        a.in_vld  = 1'b0;
        a.in_sel  = '0;
        a.in_data = '0;
        a.out_rdy = '0;
        b.in_vld  = 1'b0;
        b.in_sel  = '0;
        b.in_data = '0;
        b.out_rdy = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld", 64'(a.out_vld), 64'(0));
        check("rst_out_data", 64'(a.out_data[63:0]), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_in_rdy", 64'(a.in_rdy), 64'(0));
        rst = 1'b0;
        tick();

        // Basic route to channel 2
        a.out_rdy = 5'b11111;
        offer(5'b00100, 32'hA5A5_0001, 2);
        tick();
        check("route_accept", 64'(accepted), 64'(1));
        a.in_vld = 1'b0;
        check("route_out_vld", 64'(a.out_vld), 64'(5'b00100));
        check("route_data", 64'(a.out_data[95:64]), 64'(32'hA5A5_0001));
        check("route_err", 64'(err), 64'(0));
        tick();
        check("route_drained", 64'(a.out_vld), 64'(0));

        // Backpressure on channel 0, then drain and reload on one edge
        a.out_rdy = 5'b11110;
        offer(5'b00001, 32'hB000_0000, 0);
        tick();
        offer(5'b00001, 32'hB000_0001, 0);
        #1;
        check("bp_in_rdy_low", 64'(a.in_rdy), 64'(0));
        tick();
        check("bp_held", 64'(accepted), 64'(0));
        check("bp_out_vld", 64'(a.out_vld), 64'(5'b00001));
        check("bp_data_old", 64'(a.out_data[31:0]), 64'(32'hB000_0000));
        a.out_rdy = 5'b11111;
        #1;
        check("bp_in_rdy_high", 64'(a.in_rdy), 64'(1));
        tick();
        a.in_vld = 1'b0;
        check("bp_reload_vld", 64'(a.out_vld), 64'(5'b00001));
        check("bp_data_new", 64'(a.out_data[31:0]), 64'(32'hB000_0001));
        tick();
        check("bp_empty", 64'(a.out_vld), 64'(0));

        // Independent channels: 1 stalled, 3 still accepts
        a.out_rdy = 5'b10101;
        offer(5'b00010, 32'hC000_0001, 1);
        tick();
        offer(5'b01000, 32'hC000_0003, 3);
        #1;
        check("ind_in_rdy", 64'(a.in_rdy), 64'(1));
        tick();
        a.in_vld = 1'b0;
        check("ind_out_vld", 64'(a.out_vld), 64'(5'b01010));
        a.out_rdy = 5'b10111;
        tick();
        check("ind_release1", 64'(a.out_vld), 64'(5'b01000));
        a.out_rdy = 5'b11111;
        tick();
        check("ind_empty", 64'(a.out_vld), 64'(0));

        // Illegal selects
        offer(5'b00110, 32'hD000_0000, -1);
        #1;
        check("ill_in_rdy", 64'(a.in_rdy), 64'(1));
        tick();
        offer(5'b00000, 32'hD000_0001, -1);
        tick();
        check("ill_zero_accept", 64'(accepted), 64'(1));
        a.in_vld = 1'b0;
        check("ill_out_vld", 64'(a.out_vld), 64'(0));
        check("ill_err", 64'(err), 64'(1));
        check("ill_err_cnt", 64'(err_cnt), 64'(2));
        offer(5'b11000, 32'hD000_0002, -1);
        err_clr = 1'b1;
        tick();
        err_clr  = 1'b0;
        a.in_vld = 1'b0;
        check("clr_ill_err", 64'(err), 64'(1));
        check("clr_ill_cnt", 64'(err_cnt), 64'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err", 64'(err), 64'(0));
        check("clr_cnt", 64'(err_cnt), 64'(0));

        // Counter saturation
        offer(5'b11111, 32'hDEAD_BEEF, -1);
        for (int i = 0; i < 300; i++) tick();
        a.in_vld = 1'b0;
        check("sat_cnt", 64'(err_cnt), 64'(255));
        check("sat_err", 64'(err), 64'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sat_clr_err", 64'(err), 64'(0));
        check("sat_clr_cnt", 64'(err_cnt), 64'(0));
        check("sb_all_delivered", 64'(sb.size()), 64'(0));

        // No checking: lowest set bit wins, zero select dropped silently
        b.in_vld  = 1'b1;
        b.in_sel  = 5'b10110;
        b.in_data = 32'hE000_0001;
        @(negedge clk);
        check("nc_in_rdy", 64'(b.in_rdy), 64'(1));
        @(posedge clk);
        #1;
        b.in_sel = 5'b00000;
        check("nc_out_vld", 64'(b.out_vld), 64'(5'b00010));
        check("nc_data", 64'(b.out_data[63:32]), 64'(32'hE000_0001));
        check("nc_err", 64'(err0), 64'(0));
        @(negedge clk);
        check("nc_zero_rdy", 64'(b.in_rdy), 64'(1));
        @(posedge clk);
        #1;
        b.in_vld = 1'b0;
        check("nc_zero_out_vld", 64'(b.out_vld), 64'(5'b00010));
        check("nc_zero_err_cnt", 64'(err_cnt0), 64'(0));

        // Asynchronous reset with full slots
        a.out_rdy = 5'b00000;
        offer(5'b00001, 32'hF000_0000, 0);
        tick();
        offer(5'b10000, 32'hF000_0004, 4);
        tick();
        offer(5'b00011, 32'hF000_0005, -1);
        tick();
        a.in_vld = 1'b0;
        check("pre_rst_vld", 64'(a.out_vld), 64'(5'b10001));
        check("pre_rst_cnt", 64'(err_cnt), 64'(1));
        offer(5'b00100, 32'hF000_0006, 2);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("arst_out_vld", 64'(a.out_vld), 64'(0));
        check("arst_out_data", 64'(a.out_data[63:0]), 64'(0));
        check("arst_err", 64'(err), 64'(0));
        check("arst_err_cnt", 64'(err_cnt), 64'(0));
        check("arst_in_rdy", 64'(a.in_rdy), 64'(0));
        check("arst_nc_out_vld", 64'(b.out_vld), 64'(0));
        a.in_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a.out_rdy = 5'b11111;
        tick();
        tick();
        check("post_rst_vld", 64'(a.out_vld), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/one_hot_demux.md
Name: one_hot_demux

Overview:
Routes a single valid/ready input stream to one of CNT output channels, selected by a one-hot select that travels with each beat. Each output channel has a one-entry register slice, giving 1-cycle latency and independent per-channel backpressure. Illegal (zero or multi-hot) selects are dropped and logged in a sticky error flag and a saturating counter. This is the distribution-side counterpart of one_hot_mux: it fans one source out to CNT sinks, where the mux gathers CNT sources into one.

Parameters:
WIDTH, 32, data width of one channel
CNT, 5, number of output channels
ONE_HOT_CHECK, 1, 1 = detect, drop and count illegal selects; 0 = no checking, lowest set bit wins

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_vld  input  1  input beat valid
in_rdy  output  1  input beat accepted when in_vld & in_rdy
in_data  input  WIDTH  input payload
in_sel  input  CNT  one-hot destination select, qualified by in_vld
out_vld  output  CNT  per-channel valid; bit c belongs to channel c
out_rdy  input  CNT  per-channel ready
out_data  output  WIDTH*CNT  channel c occupies bits [(c+1)*WIDTH-1 : c*WIDTH]
err  output  1  sticky illegal-select flag
err_clr  input  1  synchronous clear of err and err_cnt
err_cnt  output  8  saturating count of dropped illegal beats

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_vld=0, out_data=0, err=0, err_cnt=0. Any beat held in a slot is discarded on reset, including mid-transfer. in_rdy is 0 during reset.
- Slot c states:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on out_vld[c] & out_rdy[c] with no simultaneous load.
  - FULL stays FULL on a drain with a simultaneous load; the new data replaces the old in the same edge.
- Channel decode:
  - ONE_HOT_CHECK=1: tgt = in_sel when popcount(in_sel)==1; otherwise the beat is illegal.
  - ONE_HOT_CHECK=0: tgt = lowest set bit of in_sel. in_sel==0 is dropped silently.
- in_rdy:
  - Legal beat: in_rdy = ~out_vld[tgt] | out_rdy[tgt]. This is combinational from out_rdy, so back-to-back full throughput is possible per channel.
  - Illegal or dropped beat: in_rdy = 1, the beat is consumed and discarded.
- Load: when in_vld & in_rdy on a legal beat, slot tgt captures in_data and out_vld[tgt]=1 at the next edge. Latency is 1 cycle.
- Channel independence:
  - Only the target slot changes on a load.
  - Other slots drain independently in the same cycle.
  - Empty slots hold their last data.
  - Out_data of an empty slot is don't-care for checking.
- Ordering: beats to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Error logging, on each accepted illegal beat with ONE_HOT_CHECK=1:
  - err is set to 1 at the next edge.
  - err_cnt increments and saturates at 255.
- err_clr:
  - Clears err and err_cnt at the next edge.
  - If err_clr coincides with an illegal beat, the result is err=1, err_cnt=1.
- ONE_HOT_CHECK=0: err and err_cnt are tied to 0.
- in_sel and in_data are ignored when in_vld=0. No error is logged for X or zero select without in_vld.

Test Plan:
- Reset and basic route: rst pulse, then in_vld=1, in_sel=5'b00100, in_data=32'hA5A5_0001, out_rdy=all ones -> next cycle out_vld=5'b00100, out_data[95:64]=32'hA5A5_0001, other out_vld bits 0, err=0.
- Backpressure: load channel 0, out_rdy[0]=0, then offer a second beat to channel 0 -> in_rdy=0 and the beat is held. Raise out_rdy[0] -> the first beat drains and the second loads in the same edge. out_vld[0] stays 1 and data is delivered in order.
- Independent channels: channel 1 full with out_rdy[1]=0. Send to channel 3 -> in_rdy=1, out_vld=5'b01010. Release out_rdy[1] -> out_vld=5'b01000.
- Illegal selects: send in_sel=5'b00110, then 5'b00000 -> both accepted (in_rdy=1), out_vld unchanged, err=1, err_cnt=2. Pulse err_clr on the same cycle as a third illegal beat -> err=1, err_cnt=1.
- Counter saturation: 300 illegal beats -> err_cnt=255. err_clr -> err=0, err_cnt=0.
- ONE_HOT_CHECK=0 and reset mid-operation:
  - With ONE_HOT_CHECK=0, in_sel=5'b10110 -> lands on channel 1, err=0.
  - Async rst asserted while slots are full and out_rdy=0 -> out_vld=0 immediately without a clock edge, err_cnt=0.
